fixed_point_issue_unit: RTL and testbench

Request sequencer that sits directly upstream of the fixed-point unit and owns its operand/operation inputs. Accepts operation requests over a valid/ready handshake, buffers up to two in a FIFO, and drives one request at a time into the FPU. It holds the FPU inputs stable and waits for a trustworthy `ready`, with a timeout guard. The captured result is returned with the request's tag over a second valid/ready handshake.

---
 rtl/fixed_point_issue_unit_if.sv | 45 ++++
 rtl/fixed_point_issue_unit.sv | 188 ++++++++++++++++++
 tb/tb_fixed_point_issue_unit.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_issue_unit_if.sv
// Request/response bundle between a caller and fixed_point_issue_unit.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both 1. The source holds valid and its payload
// stable until that edge. The sink may raise or lower ready at any time.
//
// Ports (signals):
//   req_valid, req_operation, req_operand_1, req_operand_2, req_tag : caller -> unit
//   req_ready                                                      : unit -> caller
//   rsp_valid, rsp_result, rsp_tag, rsp_timeout                    : unit -> consumer
//   rsp_ready                                                      : consumer -> unit
// Modports:
//   master : the caller/consumer side
//   slave  : the issue unit side
interface fixed_point_issue_unit_if #(
   parameter int WIDTH     = 32,
   parameter int TAG_WIDTH = 4
);
   logic                 req_valid;
   logic                 req_ready;
   logic [1:0]           req_operation;
   logic [WIDTH-1:0]     req_operand_1;
   logic [WIDTH-1:0]     req_operand_2;
   logic [TAG_WIDTH-1:0] req_tag;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [WIDTH-1:0]     rsp_result;
   logic [TAG_WIDTH-1:0] rsp_tag;
   logic                 rsp_timeout;

   modport master (
      output req_valid, req_operation, req_operand_1, req_operand_2, req_tag,
      input  req_ready,
      input  rsp_valid, rsp_result, rsp_tag, rsp_timeout,
      output rsp_ready
   );

   modport slave (
      input  req_valid, req_operation, req_operand_1, req_operand_2, req_tag,
      output req_ready,
      output rsp_valid, rsp_result, rsp_tag, rsp_timeout,
      input  rsp_ready
   );
endinterface

// File: rtl/fixed_point_issue_unit.sv
// Request sequencer in front of the fixed-point unit (FPU).
// Requests are buffered in a 2-entry FIFO. One request at a time is driven
// into the FPU. The unit waits for a trustworthy fpu_ready and gives up after
// TIMEOUT wait cycles. The result is returned with the request tag.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   bus            request/response handshakes (fixed_point_issue_unit_if.slave)
//   fpu_operand_1  operand 1 to the FPU; holds its last value outside ISSUE/WAIT
//   fpu_operand_2  operand 2 to the FPU; holds its last value outside ISSUE/WAIT
//   fpu_operation  operation to the FPU; FPU_ADD outside ISSUE/WAIT
//   fpu_result     result from the FPU
//   fpu_ready      ready from the FPU
//   busy           FSM not idle, or FIFO not empty
//   state_dbg      current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
module fixed_point_issue_unit #(
   parameter int WIDTH     = 32,
   parameter int TAG_WIDTH = 4,
   parameter int MIN_WAIT  = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   fixed_point_issue_unit_if.slave bus,
   output logic [WIDTH-1:0]     fpu_operand_1,
   output logic [WIDTH-1:0]     fpu_operand_2,
   output logic [1:0]           fpu_operation,
   input  logic [WIDTH-1:0]     fpu_result,
   input  logic                 fpu_ready,
   output logic                 busy,
   output logic [1:0]           state_dbg
);

   localparam logic [1:0] FPU_ADD  = 2'd0;
   localparam logic [1:0] FPU_SUB  = 2'd1;
   localparam logic [1:0] FPU_MUL  = 2'd2;
   localparam logic [1:0] FPU_SQRT = 2'd3;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_WAIT);

   logic [1:0]           state;

   // FIFO storage and pointers
   logic [1:0]           fifo_op   [2];
   logic [WIDTH-1:0]     fifo_opa  [2];
   logic [WIDTH-1:0]     fifo_opb  [2];
   logic [TAG_WIDTH-1:0] fifo_tag  [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           count;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;

   // Issued request
   logic [1:0]           iss_op;
   logic [WIDTH-1:0]     iss_opa;
   logic [WIDTH-1:0]     iss_opb;
   logic [TAG_WIDTH-1:0] iss_tag;

   logic [CNT_W-1:0]     wait_cnt;
   logic                 slow_op;
   logic                 honoured;

   logic [WIDTH-1:0]     rsp_result_q;
   logic [TAG_WIDTH-1:0] rsp_tag_q;
   logic                 rsp_timeout_q;

   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);
   // req_ready depends only on "full". A pop in the same cycle does not free a slot early.
   assign push  = bus.req_valid && !full;
   assign pop   = (state == IDLE) && !empty;

   // MUL and SQRT can leave ready high from the previous operation, so their
   // first MIN_WAIT wait cycles ignore fpu_ready.
   always_comb begin
      slow_op = 1'b1;
      case (iss_op)
         FPU_ADD, FPU_SUB:  slow_op = 1'b0;
         FPU_MUL, FPU_SQRT: slow_op = 1'b1;
         default:           slow_op = 1'b1;
      endcase
   end

   assign honoured = fpu_ready && (!slow_op || (wait_cnt >= MIN_CNT));

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset. The pointers and count qualify it.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr]  <= bus.req_operation;
         fifo_opa[wr_ptr] <= bus.req_operand_1;
         fifo_opb[wr_ptr] <= bus.req_operand_2;
         fifo_tag[wr_ptr] <= bus.req_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         iss_op        <= FPU_ADD;
         iss_opa       <= '0;
         iss_opb       <= '0;
         iss_tag       <= '0;
         wait_cnt      <= '0;
         rsp_result_q  <= '0;
         rsp_tag_q     <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  iss_op  <= fifo_op[rd_ptr];
                  iss_opa <= fifo_opa[rd_ptr];
                  iss_opb <= fifo_opb[rd_ptr];
                  iss_tag <= fifo_tag[rd_ptr];
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               // A ready that is honoured on the last cycle takes priority over the timeout.
               if (honoured) begin
                  rsp_result_q  <= fpu_result;
                  rsp_timeout_q <= 1'b0;
                  rsp_tag_q     <= iss_tag;
                  state         <= RESP;
               end else if (wait_cnt == LAST_CNT) begin
                  rsp_result_q  <= '0;
                  rsp_timeout_q <= 1'b1;
                  rsp_tag_q     <= iss_tag;
                  state         <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (bus.rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready   = !full;
   assign bus.rsp_valid   = (state == RESP);
   assign bus.rsp_result  = rsp_result_q;
   assign bus.rsp_tag     = rsp_tag_q;
   assign bus.rsp_timeout = rsp_timeout_q;

   // Outside ISSUE/WAIT the FPU sees ADD. A held MUL/SQRT code would otherwise
   // start the FPU again.
   assign fpu_operation = ((state == ISSUE) || (state == WAIT)) ? iss_op : FPU_ADD;
   assign fpu_operand_1 = iss_opa;
   assign fpu_operand_2 = iss_opb;

   assign busy      = (state != IDLE) || !empty;
   assign state_dbg = state;

endmodule

// File: tb/tb_fixed_point_issue_unit.sv
module tb_fixed_point_issue_unit;
   localparam int WIDTH     = 32;
   localparam int TAG_WIDTH = 4;
   localparam int MIN_WAIT  = 2;
   localparam int TIMEOUT   = 64;
   localparam int EW        = TAG_WIDTH + 1 + 8 + WIDTH;

   localparam logic [1:0] FPU_ADD  = 2'd0;
   localparam logic [1:0] FPU_SUB  = 2'd1;
   localparam logic [1:0] FPU_MUL  = 2'd2;
   localparam logic [1:0] FPU_SQRT = 2'd3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fixed_point_issue_unit_if #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

   logic [WIDTH-1:0] fpu_operand_1, fpu_operand_2, fpu_result;
   logic [1:0]       fpu_operation, state_dbg;
   logic             fpu_ready, busy;

   fixed_point_issue_unit #(
      .WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave),
      .fpu_operand_1(fpu_operand_1),
      .fpu_operand_2(fpu_operand_2),
      .fpu_operation(fpu_operation),
      .fpu_result(fpu_result),
      .fpu_ready(fpu_ready),
      .busy(busy),
      .state_dbg(state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int n_vec  = 0;
   int n_fail = 0;
   // expected response: {tag, timeout, wait_cycles[7:0], result}
   logic [EW-1:0] exp_q[$];
   // FPU behaviour per request in issue order: {stale_cycles[7:0], ready_at[7:0]}
   logic [15:0]   sched_q[$];
   int rsp_mode = 2;  // 0 = random rsp_ready, 1 = hold low, 2 = hold high

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stand-in FPU arithmetic. The unit must pass it through bit-exact.
   function automatic logic [WIDTH-1:0] fpu_fn(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      case (op)
         FPU_ADD: return a + b;
         FPU_SUB: return a - b;
         FPU_MUL: return a * b;
         default: return (a >> 1) ^ 32'h00C0FFEE;
      endcase
   endfunction

   // Reference model. The FPU holds ready=1 with a garbage result for "stale"
   // wait cycles, then ready=0, then ready=1 with the true result from wait cycle
   // "ready_at" onward. ADD/SUB take the first ready. MUL/SQRT take the first
   // ready at index >= MIN_WAIT. A request that is not done by index TIMEOUT-1
   // times out.
   task automatic model_push(input logic [1:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic [TAG_WIDTH-1:0] tag,
                             input int stale, input int ready_at);
      int h;
      logic [EW-1:0] e;
      if (op == FPU_ADD || op == FPU_SUB) h = ready_at;
      else h = (ready_at < MIN_WAIT) ? MIN_WAIT : ready_at;
      if (h <= TIMEOUT - 1) e = {tag, 1'b0, 8'(h + 1), fpu_fn(op, a, b)};
      else                  e = {tag, 1'b1, 8'(TIMEOUT), {WIDTH{1'b0}}};
      exp_q.push_back(e);
      sched_q.push_back({8'(stale), 8'(ready_at)});
   endtask

   // ---------------- driver tasks ----------------
   task automatic push_req(input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [TAG_WIDTH-1:0] tag,
                           input int stale, input int ready_at);
      int guard = 0;
      @(negedge clk);
      while (!bus.req_ready && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.req_ready) begin
         check("req_ready_wait_expired", 64'(bus.req_ready), 64'd1);
         return;
      end
      bus.req_valid     = 1'b1;
      bus.req_operation = op;
      bus.req_operand_1 = a;
      bus.req_operand_2 = b;
      bus.req_tag       = tag;
      model_push(op, a, b, tag, stale, ready_at);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("drain_expired", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_req_ready"},   64'(bus.req_ready),   64'd1);
      check({pfx, "_rsp_valid"},   64'(bus.rsp_valid),   64'd0);
      check({pfx, "_rsp_result"},  64'(bus.rsp_result),  64'd0);
      check({pfx, "_rsp_tag"},     64'(bus.rsp_tag),     64'd0);
      check({pfx, "_rsp_timeout"}, 64'(bus.rsp_timeout), 64'd0);
      check({pfx, "_busy"},        64'(busy),            64'd0);
      check({pfx, "_fpu_op"},      64'(fpu_operation),   64'(FPU_ADD));
      check({pfx, "_fpu_opa"},     64'(fpu_operand_1),   64'd0);
      check({pfx, "_fpu_opb"},     64'(fpu_operand_2),   64'd0);
      check({pfx, "_state"},       64'(state_dbg),       64'(ST_IDLE));
   endtask

   // ---------------- behavioural FPU ----------------
   logic        in_wait = 1'b0;
   int          fpu_idx = 0;
   logic [15:0] cur_sched = 16'h00FF;
   logic [WIDTH-1:0] good;

   initial begin
      fpu_ready  = 1'b0;
      fpu_result = '0;
   end

   always @(negedge clk) begin
      if (state_dbg == ST_WAIT) begin
         if (!in_wait) begin
            fpu_idx   = 0;
            cur_sched = (sched_q.size() != 0) ? sched_q.pop_front() : 16'h00FF;
         end else begin
            fpu_idx++;
         end
         in_wait = 1'b1;
         good = fpu_fn(fpu_operation, fpu_operand_1, fpu_operand_2);
         if (fpu_idx < int'(cur_sched[15:8])) begin
            fpu_ready  = 1'b1;
            fpu_result = ~good;
         end else if (fpu_idx < int'(cur_sched[7:0])) begin
            fpu_ready  = 1'b0;
            fpu_result = $urandom;
         end else begin
            fpu_ready  = 1'b1;
            fpu_result = good;
         end
      end else begin
         in_wait    = 1'b0;
         fpu_ready  = 1'($urandom_range(0, 1));
         fpu_result = $urandom;
      end
   end

   // ---------------- monitor ----------------
   logic             pending = 1'b0;
   int               wait_cycles = 0;
   logic [EW-1:0]    e;
   logic [TAG_WIDTH+WIDTH:0] held;

   initial bus.rsp_ready = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         pending     = 1'b0;
         wait_cycles = 0;
      end else begin
         if (state_dbg == ST_ISSUE) wait_cycles = 0;
         else if (state_dbg == ST_WAIT) wait_cycles++;
         if (bus.rsp_valid) begin
            if (!pending) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_rsp: got tag %0d result 0x%0h, required no response (t=%0t)",
                           bus.rsp_tag, bus.rsp_result, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_result",  64'(bus.rsp_result),  64'(e[WIDTH-1:0]));
                  check("rsp_latency", 64'(wait_cycles),     64'(e[WIDTH+7:WIDTH]));
                  check("rsp_timeout", 64'(bus.rsp_timeout), 64'(e[WIDTH+8]));
                  check("rsp_tag",     64'(bus.rsp_tag),     64'(e[EW-1:WIDTH+9]));
               end
               held = {bus.rsp_tag, bus.rsp_timeout, bus.rsp_result};
            end else begin
               check("rsp_stable", 64'({bus.rsp_tag, bus.rsp_timeout, bus.rsp_result}), 64'(held));
            end
            check("fpu_op_in_resp", 64'(fpu_operation), 64'(FPU_ADD));
         end
         case (rsp_mode)
            0:       bus.rsp_ready = 1'($urandom_range(0, 1));
            1:       bus.rsp_ready = 1'b0;
            default: bus.rsp_ready = 1'b1;
         endcase
         pending = bus.rsp_valid && !bus.rsp_ready;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [1:0] op;
      int r, d, stale;
      int guard;

      bus.req_valid     = 1'b0;
      bus.req_operation = FPU_ADD;
      bus.req_operand_1 = '0;
      bus.req_operand_2 = '0;
      bus.req_tag       = '0;

      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      reset = 1'b1;

      // ADD: rsp_valid exactly 3 cycles after acceptance
      rsp_mode = 2;
      push_req(FPU_ADD, 32'h0000_0600, 32'h0000_0800, 4'd3, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk);
         #1;
         check("add_latency_valid", 64'(bus.rsp_valid), 64'(i == 3));
      end
      drain();

      // MUL with stale ready: 2 stale cycles, 5 low, then true result 0xC00
      push_req(FPU_MUL, 32'h0000_0030, 32'h0000_0040, 4'd5, 2, 7);
      drain();

      // SQRT timeout: ready never rises
      push_req(FPU_SQRT, 32'h0000_1000, $urandom, 4'd7, 0, 255);
      drain();

      // Timeout boundary: ready on the last wait cycle wins, one later loses
      push_req(FPU_ADD, $urandom, $urandom, 4'd8, 0, TIMEOUT - 1);
      push_req(FPU_SUB, $urandom, $urandom, 4'd9, 0, TIMEOUT);
      push_req(FPU_SQRT, $urandom, $urandom, 4'd10, MIN_WAIT, TIMEOUT - 1);
      drain();

      // Backpressure: three requests fill issue + FIFO
      rsp_mode = 1;
      push_req(FPU_ADD, $urandom, $urandom, 4'd1, 0, 0);
      push_req(FPU_SUB, $urandom, $urandom, 4'd2, 0, 1);
      push_req(FPU_MUL, $urandom, $urandom, 4'd3, 1, 3);
      check("bp_req_ready_full", 64'(bus.req_ready), 64'd0);
      repeat (6) @(posedge clk);
      #1;
      check("bp_still_full", 64'(bus.req_ready), 64'd0);
      check("bp_rsp_held", 64'(bus.rsp_valid), 64'd1);
      rsp_mode = 2;
      drain();

      // Push/pop on the same edge: the FIFO holds one entry and the FSM is IDLE
      push_req(FPU_ADD, $urandom, $urandom, 4'd4, 0, 5);
      push_req(FPU_SUB, $urandom, $urandom, 4'd5, 0, 5);
      check("pp_req_ready", 64'(bus.req_ready), 64'd1);
      check("pp_state_issue", 64'(state_dbg), 64'(ST_ISSUE));
      push_req(FPU_ADD, $urandom, $urandom, 4'd6, 0, 5);
      check("pp_full_after_third", 64'(bus.req_ready), 64'd0);
      drain();

      // Reset during WAIT with one request queued
      push_req(FPU_SQRT, $urandom, $urandom, 4'd11, 0, 255);
      push_req(FPU_ADD, $urandom, $urandom, 4'd12, 0, 0);
      guard = 0;
      @(negedge clk);
      while (state_dbg != ST_WAIT && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("rst_reached_wait", 64'(state_dbg), 64'(ST_WAIT));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      sched_q.delete();
      @(posedge clk);
      #1;
      check_reset_values("midreset");
      @(negedge clk);
      reset = 1'b1;
      repeat (100) @(negedge clk);
      check("midreset_busy_after", 64'(busy), 64'd0);

      // Randomised traffic
      rsp_mode = 0;
      for (int n = 0; n < 150; n++) begin
         op = 2'($urandom_range(0, 3));
         r  = $urandom_range(0, 9);
         d  = (r < 8) ? $urandom_range(0, 12) : $urandom_range(TIMEOUT - 4, TIMEOUT + 2);
         stale = (op == FPU_MUL || op == FPU_SQRT) ? $urandom_range(0, MIN_WAIT) : 0;
         push_req(op, $urandom, $urandom, 4'($urandom), stale, d);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      rsp_mode = 2;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
